// File: rtl/tx_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_REQ beat streams onto one registered tx stream.
// Optional macro TX_ARB_BARRIER_PRIO_EN gives requester NUM_REQ-1 priority in IDLE.
module tx_stream_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]      req_connection_id,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic [3:0]                tx_connection_id,
  output logic                      tx_last,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      arb_busy,
  output logic [2:0]                arb_grant
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  localparam logic [2:0] BarrierIdx = 3'(NUM_REQ - 1);

  state_e            state_q, state_d;
  logic [2:0]        cur_q, cur_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        rr_sel, scan, sel;
  logic              rr_found, eligible, sel_barrier;
  logic              load, accept;
  logic [7:0]        valid_ext;
  logic [DATA_W-1:0] sel_data;
  logic [3:0]        sel_conn;
  logic              sel_last, sel_valid;

  logic [DATA_W-1:0] tx_data_q;
  logic [3:0]        tx_conn_q;
  logic              tx_last_q, tx_valid_q;
  logic [2:0]        grant_q;

  assign load      = ~tx_valid_q | tx_ready;
  assign valid_ext = 8'(req_valid);

  // Scan upward from rr_ptr+1, wrapping at NUM_REQ.
  always_comb begin
    rr_sel   = rr_ptr_q;
    rr_found = 1'b0;
    scan     = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = (scan == BarrierIdx) ? 3'd0 : scan + 3'd1;
      if (!rr_found && valid_ext[scan]) begin
        rr_found = 1'b1;
        rr_sel   = scan;
      end
    end
  end

  always_comb begin
    sel         = rr_sel;
    eligible    = rr_found;
    sel_barrier = 1'b0;
    if (state_q == StLocked) begin
      sel      = cur_q;
      eligible = 1'b1;
    end
`ifdef TX_ARB_BARRIER_PRIO_EN
    else if (req_valid[NUM_REQ-1]) begin
      sel         = BarrierIdx;
      eligible    = 1'b1;
      sel_barrier = 1'b1;
    end
`endif
  end

  always_comb begin
    sel_data  = '0;
    sel_conn  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == sel) begin
        sel_data     = req_data[i*DATA_W +: DATA_W];
        sel_conn     = req_connection_id[i*4 +: 4];
        sel_last     = req_last[i];
        sel_valid    = req_valid[i];
        req_ready[i] = eligible & load & ~reset;
      end
    end
  end

  assign accept = eligible & load & sel_valid;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!sel_last) begin
            state_d = StLocked;
            cur_d   = sel;
          end
          // A priority barrier grant leaves the rotation of the others untouched.
          if (!sel_barrier) rr_ptr_d = sel;
        end
      end
      StLocked: begin
        if (accept && sel_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      rr_ptr_q <= BarrierIdx;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_q  <= '0;
      tx_conn_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
    end else if (accept) begin
      tx_data_q  <= sel_data;
      tx_conn_q  <= sel_conn;
      tx_last_q  <= sel_last;
      tx_valid_q <= 1'b1;
      grant_q    <= sel;
    end else if (load) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_data          = tx_data_q;
  assign tx_connection_id = tx_conn_q;
  assign tx_last          = tx_last_q;
  assign tx_valid         = tx_valid_q;
  assign arb_busy         = (state_q == StLocked);
  assign arb_grant        = grant_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter: directed packets, hand-ordered expected beat queue.
module tb_tx_stream_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 128;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ*4-1:0]      req_connection_id = '0;
  logic [NUM_REQ-1:0]        req_last = '0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic [3:0]                tx_connection_id;
  logic                      tx_last;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      arb_busy;
  logic [2:0]                arb_grant;

  tx_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_data          (req_data),
    .req_connection_id (req_connection_id),
    .req_last          (req_last),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .tx_data           (tx_data),
    .tx_connection_id  (tx_connection_id),
    .tx_last           (tx_last),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .arb_busy          (arb_busy),
    .arb_grant         (arb_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   conn;
    logic         last;
  } beat_t;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   conn;
    logic         last;
    logic [2:0]   grant;
  } exp_t;

  beat_t            req_q[NUM_REQ][$];
  exp_t             exp_q[$];
  int               hs_cyc[$];
  logic [NUM_REQ-1:0] en = '1;
  logic [NUM_REQ-1:0] hs_s;
  int               checks = 0;
  int               errors = 0;
  int               popped = 0;
  int               cyc = 0;
  bit               lat_chk = 1'b0;
  exp_t             e;
  int               hc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] mk_data(int r, int p, int b);
    logic [31:0] t;
    t = 32'(r * 256 + p * 16 + b);
    return {t, ~t, t ^ 32'h5A5A_5A5A, t ^ 32'hC0DE_0000};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic send(int r, int p, int n, logic [3:0] conn);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = mk_data(r, p, k);
      b.conn = conn;
      b.last = (k == n - 1);
      req_q[r].push_back(b);
    end
  endtask

  task automatic expect_pkt(int r, int p, int n, logic [3:0] conn);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.data  = mk_data(r, p, k);
      x.conn  = conn;
      x.last  = (k == n - 1);
      x.grant = 3'(r);
      exp_q.push_back(x);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && req_q[i].size() > 0) begin
        req_valid[i]                 = 1'b1;
        req_data[i*DATA_W +: DATA_W] = req_q[i][0].data;
        req_connection_id[i*4 +: 4]  = req_q[i][0].conn;
        req_last[i]                  = req_q[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_REQ; i++) req_q[i].delete();
    exp_q.delete();
    hs_cyc.delete();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (req_q[i].size() > 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic wait_drain(string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (all_empty()) return;
    end
    checks++;
    errors++;
    $display("FAIL %s drain timeout: got %0d beats outstanding expected 0", name, exp_q.size());
    flush();
  endtask

  task automatic wait_popped(string name, int target);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (popped >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout: got %0d beats expected %0d", name, popped, target);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Request driver: sample handshakes at negedge, retire accepted beats after the edge.
  initial begin
    drive();
    forever begin
      @(negedge clk);
      hs_s = reset ? '0 : (req_valid & req_ready);
      if (|hs_s) hs_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (hs_s[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
      drive();
    end
  end

  // Output monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected beat: got data %0h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e.data);
          check("tx_connection_id", 128'(tx_connection_id), 128'(e.conn));
          check("tx_last", 128'(tx_last), 128'(e.last));
          check("arb_grant", 128'(arb_grant), 128'(e.grant));
        end
        if (hs_cyc.size() > 0) begin
          hc = hs_cyc.pop_front();
          if (lat_chk) check("latency", 128'(cyc - hc), 128'(1));
        end
        popped++;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst tx_valid", 128'(tx_valid), 128'(0));
    check("rst tx_data", tx_data, 128'(0));
    check("rst tx_conn", 128'(tx_connection_id), 128'(0));
    check("rst tx_last", 128'(tx_last), 128'(0));
    check("rst arb_busy", 128'(arb_busy), 128'(0));
    check("rst arb_grant", 128'(arb_grant), 128'(0));
    check("rst req_ready", 128'(req_ready), 128'(0));
    @(posedge clk);
    #2 reset = 1'b0;
    tx_ready = 1'b1;

    // Single requester, 3-beat packet, one-cycle latency per beat.
    lat_chk = 1'b1;
    send(2, 0, 3, 4'd5);
    expect_pkt(2, 0, 3, 4'd5);
    wait_drain("single");
    lat_chk = 1'b0;

    // Atomicity: req 1 appears after req 0's first beat and must wait.
    en[1] = 1'b0;
    send(0, 1, 4, 4'd1);
    send(1, 1, 2, 4'd2);
    expect_pkt(0, 1, 4, 4'd1);
    expect_pkt(1, 1, 2, 4'd2);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (arb_busy) break;
    end
    @(posedge clk);
    #2 en[1] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_q[0].size() == 0) break;
      if (req_valid[1]) check("atomic req_ready[1]", 128'(req_ready[1]), 128'(0));
    end
    wait_drain("atomic");

    // Round-robin rotation with all requesters valid.
    pulse_reset();
    send(0, 2, 1, 4'd0);
    send(0, 3, 1, 4'd0);
    send(1, 2, 1, 4'd1);
    send(1, 3, 1, 4'd1);
    send(2, 2, 1, 4'd2);
    send(3, 2, 1, 4'd3);
`ifdef TX_ARB_BARRIER_PRIO_EN
    expect_pkt(3, 2, 1, 4'd3);
    expect_pkt(0, 2, 1, 4'd0);
    expect_pkt(1, 2, 1, 4'd1);
    expect_pkt(2, 2, 1, 4'd2);
`else
    expect_pkt(0, 2, 1, 4'd0);
    expect_pkt(1, 2, 1, 4'd1);
    expect_pkt(2, 2, 1, 4'd2);
    expect_pkt(3, 2, 1, 4'd3);
`endif
    expect_pkt(0, 3, 1, 4'd0);
    expect_pkt(1, 3, 1, 4'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_valid) break;
    end
    check("rr tx_valid 0", 128'(tx_valid), 128'(1));
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      check("rr tx_valid run", 128'(tx_valid), 128'(1));
    end
    wait_drain("rr");

    // Backpressure mid-packet: output holds, nothing accepted.
    popped = 0;
    send(1, 4, 4, 4'd9);
    expect_pkt(1, 4, 4, 4'd9);
    wait_popped("bp", 2);
    @(posedge clk);
    #2 tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall tx_valid", 128'(tx_valid), 128'(1));
      check("stall tx_data", tx_data, mk_data(1, 4, 2));
      check("stall tx_last", 128'(tx_last), 128'(0));
      check("stall req_ready", 128'(req_ready), 128'(0));
    end
    @(posedge clk);
    #2 tx_ready = 1'b1;
    wait_drain("bp");

    // Barrier vs round-robin with rr_ptr=0.
    pulse_reset();
    send(0, 5, 1, 4'd3);
    expect_pkt(0, 5, 1, 4'd3);
    wait_drain("bar setup");
    send(1, 6, 1, 4'd1);
    send(3, 6, 1, 4'd7);
`ifdef TX_ARB_BARRIER_PRIO_EN
    expect_pkt(3, 6, 1, 4'd7);
    expect_pkt(1, 6, 1, 4'd1);
`else
    expect_pkt(1, 6, 1, 4'd1);
    expect_pkt(3, 6, 1, 4'd7);
`endif
    wait_drain("barrier");

    // Reset during beat 2 of a 4-beat packet.
    popped = 0;
    send(0, 7, 4, 4'd2);
    expect_pkt(0, 7, 4, 4'd2);
    wait_popped("mid rst", 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid rst tx_valid", 128'(tx_valid), 128'(0));
    check("mid rst arb_busy", 128'(arb_busy), 128'(0));
    check("mid rst req_ready", 128'(req_ready), 128'(0));
    flush();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    send(1, 8, 1, 4'd1);
    send(0, 8, 1, 4'd4);
    expect_pkt(0, 8, 1, 4'd4);
    expect_pkt(1, 8, 1, 4'd1);
    wait_drain("post rst");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_stream_arbiter.md
# tx_stream_arbiter

Packet-atomic round-robin arbiter that merges several transaction-layer requester streams onto the single 128-bit transmit stream feeding the link layer. Each requester is a 128-bit valid/ready beat stream with a last flag and a 4-bit connection id, such as an AXI request encoder, a response encoder or the barrier sender. A granted requester holds the link until its last beat is accepted. One registered output stage gives full throughput with a single cycle of latency.

## Interface
- NUM_REQ, 4, number of requesters (2..8); index NUM_REQ-1 is the barrier requester.
- DATA_W, 128, beat width.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_data  in  NUM_REQ*DATA_W  requester beats; requester i uses slice [i*DATA_W +: DATA_W].
- req_connection_id  in  NUM_REQ*4  connection id; requester i uses [i*4 +: 4].
- req_last  in  NUM_REQ  last beat of packet.
- req_valid  in  NUM_REQ  beat valid.
- req_ready  out  NUM_REQ  beat accepted when valid & ready.
- tx_data  out  DATA_W  registered output beat.
- tx_connection_id  out  4  registered connection id.
- tx_last  out  1  registered last flag.
- tx_valid  out  1  output valid.
- tx_ready  in  1  link layer accepts the beat.
- arb_busy  out  1  a packet is open (state LOCKED).
- arb_grant  out  3  index of the current or most recent granted requester.

## Operation
- States:
  - IDLE: no packet open.
  - LOCKED: a packet is open for requester cur.
- Output register can load: `load = ~tx_valid | tx_ready`.
- IDLE:
  - sel is the first i with req_valid[i], searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[sel] = load. All other req_ready are 0.
  - When beat sel is accepted with last=0: go to LOCKED, cur=sel.
  - When beat sel is accepted with last=1: stay in IDLE.
  - In both cases rr_ptr=sel.
- LOCKED:
  - Only cur is eligible: req_ready[cur] = load, all others 0.
  - Other requesters' valids are ignored. A requester never loses its grant mid-packet.
  - If req_valid[cur] drops mid-packet, the output simply drains and waits. No timeout.
  - When the cur beat with last=1 is accepted: go to IDLE. rr_ptr is already cur.
- No requester valid in IDLE: all req_ready=0 and state is unchanged.
- Accepted beat: data, connection id and last are copied unmodified into the output register and tx_valid is set to 1.
- If load=1 and no beat is accepted, tx_valid is cleared.
- arb_grant tracks sel at every accepted beat; it holds its value otherwise.
- The block has no combinational path from req_valid to tx_valid. req_ready depends combinationally on tx_ready and req_valid.

## Timing
- Reset (async assert, sync release):
  - State IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - tx_valid=0, tx_data=0, tx_connection_id=0, tx_last=0.
  - arb_busy=0, arb_grant=0, req_ready=0.
- Latency: a beat accepted at edge N appears on tx_* after edge N, valid in cycle N+1.
- Throughput: one beat per cycle while tx_ready=1. Back-to-back packets from different requesters have no bubble.
- Backpressure:
  - With tx_valid=1 and tx_ready=0, all req_ready=0 and tx_* hold stable.
  - tx_valid never drops without a handshake.
- Simultaneous events:
  - The last beat of packet A is accepted in the same cycle as the prior output beat drains. Next cycle a new IDLE selection is made. No idle cycle is inserted if a requester is valid.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0 per packet.
- Reset mid-packet: the open packet is abandoned and the output beat is discarded. The link layer sees tx_valid fall asynchronously.

## Configuration
- Macro TX_ARB_BARRIER_PRIO_EN.
- Defined:
  - In IDLE, if req_valid[NUM_REQ-1] is set, sel=NUM_REQ-1 regardless of rr_ptr.
  - Barrier selection does not update rr_ptr, so the other requesters keep their rotation.
  - Barrier priority never pre-empts a LOCKED packet.
- Undefined: the barrier requester takes part in plain round-robin like any other.

## Test plan
- Single requester, NUM_REQ=4: req 2 sends a 3-beat packet (conn 5) with tx_ready=1.
  - Expect tx_valid high for 3 consecutive cycles, each starting 1 cycle after its req handshake.
  - Expect tx_connection_id=5, tx_last only on beat 3, arb_grant=2.
- Packet atomicity: req 0 sends a 4-beat packet, and req 1 raises valid after beat 1.
  - Expect tx to carry 4 beats from req 0 before any beat from req 1.
  - Expect req_ready[1]=0 throughout req 0's packet.
- Round-robin: all 4 requesters continuously send 1-beat packets.
  - Expect grant order 0,1,2,3,0,1 with tx_valid high every cycle.
- Backpressure: tx_ready is held low for 5 cycles mid-packet.
  - Expect tx_* stable and all req_ready=0 during the stall.
  - Expect no beat lost or duplicated; beat ordering is checked by scoreboard.
- Barrier priority (macro defined): req 1 and req 3 are both valid in IDLE with rr_ptr=0.
  - Expect req 3 granted first, then req 1.
  - Without the macro, expect req 1 first.
- Reset mid-packet: assert reset during beat 2 of a 4-beat packet.
  - Expect tx_valid=0 and arb_busy=0 immediately.
  - After release, expect req 0 to win first.
